pc_next_sel: RTL

//  Parametrised next-PC selector and PC register for the fetch stage; owns the PC.

---
 rtl/pc_next_sel.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//   Fetch-stage next-PC selector. This block owns the PC register.
//   - Redirect requests from NSRC sources are arbitrated by fixed priority.
//     Index 0 has the highest priority.
//   - The PC advances by PC_STEP when there is no redirect.
//   - A redirect that arrives while stalled is held in a one-entry pending
//     buffer and is applied on the first unstalled edge. A newer request of
//     equal or higher priority replaces the buffered one.
//
// Ports
//   clk            in   1        rising-edge clock
//   rst            in   1        asynchronous, active-high reset
//   stall          in   1        hold PC this cycle
//   src_valid      in   NSRC     per-source redirect request (level)
//   src_addr       in   NSRC*AW  target of source i at [i*AW +: AW]
//   pc             out  AW       current PC (registered)
//   pcload         out  1        pulse: pc was loaded from a redirect
//   redirect_src   out  SW       index of the applied source (valid with pcload)
//   pending_valid  out  1        pending-redirect buffer occupied
//   misalign       out  1        pulse: the applied target has addr[1:0] != 0
// -----------------------------------------------------------------------------
module pc_next_sel #(
  parameter int              AW       = 32,
  parameter int              NSRC     = 3,
  parameter int              SW       = 2,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [NSRC*AW-1:0] src_addr,
  output logic [AW-1:0]      pc,
  output logic               pcload,
  output logic [SW-1:0]      redirect_src,
  output logic               pending_valid,
  output logic               misalign
);

  // The pending buffer is a two-state machine: empty or holding one redirect.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] pend_idx;
  logic [AW-1:0] pend_addr;

  logic          req;
  logic [SW-1:0] win;
  logic [AW-1:0] win_addr;
  logic          take_new;

  // Fixed-priority arbiter. The scan runs from the lowest-priority source
  // upward, so the last match (the lowest index) is the one that wins.
  // NOTE: every signal assigned in always_comb gets a default first.
  //       Otherwise a path that leaves a signal unassigned infers a latch.
  always_comb begin
    win      = '0;
    win_addr = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        win      = SW'(i);
        win_addr = src_addr[i*AW +: AW];
      end
    end
  end

  assign req = |src_valid;

  // A live request beats the buffered entry unless the buffered entry has a
  // strictly higher priority. For an equal index, the newer target wins.
  assign take_new = req && ((state == IDLE) || (win <= pend_idx));

  assign pending_valid = (state == HELD);

  // NOTE: sequential state uses non-blocking assignments only. Every
  //       register then samples pre-edge values, whatever the statement order.
  // NOTE: the buffer payload is reset together with its valid flag.
  //       The registers are few, and a deterministic post-reset value
  //       keeps the outputs free of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      pcload       <= 1'b0;
      redirect_src <= '0;
      misalign     <= 1'b0;
      state        <= IDLE;
      pend_idx     <= '0;
      pend_addr    <= '0;
    end else if (stall) begin
      pcload   <= 1'b0;
      misalign <= 1'b0;
      if (take_new) begin
        state     <= HELD;
        pend_idx  <= win;
        pend_addr <= win_addr;
      end
    end else begin
      if (take_new) begin
        pc           <= win_addr;
        redirect_src <= win;
        pcload       <= 1'b1;
        misalign     <= |win_addr[1:0];
      end else if (state == HELD) begin
        pc           <= pend_addr;
        redirect_src <= pend_idx;
        pcload       <= 1'b1;
        misalign     <= |pend_addr[1:0];
      end else begin
        // Sequential fetch. The sum is truncated to AW bits, so it wraps.
        pc       <= pc + AW'(PC_STEP);
        pcload   <= 1'b0;
        misalign <= 1'b0;
      end
      // Any unstalled edge drains the buffer. A lower-priority buffered
      // entry that lost to a live request is dropped here.
      state <= IDLE;
    end
  end

endmodule
